// File: rtl/stacking_pkg.sv
// stacking_pkg: shared types and the filter-row window function for the stacking loop controllers
package stacking_pkg;
  localparam int DEF_IFM_SIZE_Y = 7;
  localparam int DEF_FIL_SIZE_Y = 3;
  localparam int DEF_FIL_SIZE_X = 3;
  localparam int DEF_CHUNK_NUM  = 4;
  typedef logic [31:0] loop_idx_t;
  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, DRAIN, ADV, DONE} state_t;
  typedef struct packed {
    loop_idx_t start;
    loop_idx_t last;
  } fil_win_t;
  // Filter rows that IFM row `row` feeds: start = max(0, row-(out-1)), last = min(fil-1, row).
  // Signed arithmetic keeps the early rows from underflowing.
  function automatic fil_win_t fil_window(input loop_idx_t row, input int out_size_y, input int fil_size_y);
    fil_win_t w;
    int r;
    int s;
    int l;
    r = $signed(row);
    s = r - (out_size_y - 1);
    l = r < fil_size_y - 1 ? r : fil_size_y - 1;
    w.start = s < 0 ? '0 : loop_idx_t'(s);
    w.last = loop_idx_t'(l);
    return w;
  endfunction
endpackage

// File: rtl/stacking_row_window.sv
// stacking_row_window: combinational filter-row window for one IFM row
// Ports: i_row (IFM row), o_start (first contributing filter row), o_last (last contributing filter row)
module stacking_row_window
  import stacking_pkg::*;
#(
  parameter int OUT_SIZE_Y = 5,
  parameter int FIL_SIZE_Y = 3
) (
  input  loop_idx_t i_row,
  output loop_idx_t o_start,
  output loop_idx_t o_last
);
  fil_win_t w_win;
  assign w_win = fil_window(i_row, OUT_SIZE_Y, FIL_SIZE_Y);
  assign o_start = w_win.start;
  assign o_last = w_win.last;
endmodule

// File: rtl/stacking_outer_loop_ctrl.sv
// stacking_outer_loop_ctrl: chunk/row sequencer above the stacking inner loop
// Ports: clk_i/rst_ni (async active-low reset); layer_start_i, sub_channel_size_i -> sub_channel_size_o;
//   chunk_load_req_o/chunk_load_ack_i chunk load handshake; inner_loop_start_o/inner_loop_finish_i plus
//   ifm_loop_y_idx_o, fil_loop_y_idx_start_o, fil_loop_y_idx_last_o, fil_loop_y_step_o row descriptor;
//   out_row_vld_o/out_row_idx_o/out_row_rdy_i output-row drain; busy_o, layer_done_o status.
// Optional: STACKING_OUTER_PERF_EN adds perf_stall_cyc_o and perf_inner_cyc_o saturating counters.
module stacking_outer_loop_ctrl
  import stacking_pkg::*;
#(
  parameter int IFM_SIZE_Y = DEF_IFM_SIZE_Y,
  parameter int FIL_SIZE_Y = DEF_FIL_SIZE_Y,
  parameter int FIL_SIZE_X = DEF_FIL_SIZE_X,
  parameter int CHUNK_NUM  = DEF_CHUNK_NUM
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        layer_start_i,
  input  logic [31:0] sub_channel_size_i,
  output logic        chunk_load_req_o,
  input  logic        chunk_load_ack_i,
  output logic        inner_loop_start_o,
  input  logic        inner_loop_finish_i,
  output logic [31:0] ifm_loop_y_idx_o,
  output logic [31:0] fil_loop_y_idx_start_o,
  output logic [31:0] fil_loop_y_idx_last_o,
  output logic [31:0] fil_loop_y_step_o,
  output logic [31:0] sub_channel_size_o,
  output logic        out_row_vld_o,
  output logic [31:0] out_row_idx_o,
  input  logic        out_row_rdy_i,
  output logic        busy_o,
  output logic        layer_done_o
`ifdef STACKING_OUTER_PERF_EN
  ,
  output logic [31:0] perf_stall_cyc_o,
  output logic [31:0] perf_inner_cyc_o
`endif
);
  localparam int OUT_SIZE_Y = IFM_SIZE_Y - FIL_SIZE_Y + 1;
  localparam int RW = IFM_SIZE_Y > 1 ? $clog2(IFM_SIZE_Y) : 1;
  localparam int CW = CHUNK_NUM > 1 ? $clog2(CHUNK_NUM) : 1;
  state_t r_state;
  logic [RW-1:0] r_row;
  logic [CW-1:0] r_chunk;
  loop_idx_t w_row32;
  loop_idx_t w_issue_row;
  loop_idx_t w_win_start;
  loop_idx_t w_win_last;
  logic w_last_chunk;
  logic w_row_ge;
  assign fil_loop_y_step_o = 32'(FIL_SIZE_X);
  assign w_row32 = 32'(r_row);
  // ISSUE is entered from LOAD with the current row or from ADV with the incremented row;
  // the window is computed for the row being entered so the outputs land with the start pulse.
  assign w_issue_row = w_row32 + (r_state == ADV ? 32'd1 : 32'd0);
  assign w_last_chunk = r_chunk == CW'(CHUNK_NUM - 1);
  assign w_row_ge = $signed(w_row32) >= FIL_SIZE_Y - 1;
  stacking_row_window #(
    .OUT_SIZE_Y(OUT_SIZE_Y),
    .FIL_SIZE_Y(FIL_SIZE_Y)
  ) u_win (
    .i_row(w_issue_row),
    .o_start(w_win_start),
    .o_last(w_win_last)
  );
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_row <= '0;
      r_chunk <= '0;
      chunk_load_req_o <= 1'b0;
      inner_loop_start_o <= 1'b0;
      ifm_loop_y_idx_o <= '0;
      fil_loop_y_idx_start_o <= '0;
      fil_loop_y_idx_last_o <= '0;
      sub_channel_size_o <= '0;
      out_row_vld_o <= 1'b0;
      out_row_idx_o <= '0;
      busy_o <= 1'b0;
      layer_done_o <= 1'b0;
    end else begin
      inner_loop_start_o <= 1'b0;
      layer_done_o <= 1'b0;
      case (r_state)
        IDLE: if (layer_start_i) begin
          sub_channel_size_o <= sub_channel_size_i;
          r_row <= '0;
          r_chunk <= '0;
          busy_o <= 1'b1;
          chunk_load_req_o <= 1'b1;
          r_state <= LOAD;
        end
        LOAD: if (chunk_load_ack_i) begin
          chunk_load_req_o <= 1'b0;
          inner_loop_start_o <= 1'b1;
          ifm_loop_y_idx_o <= w_issue_row;
          fil_loop_y_idx_start_o <= w_win_start;
          fil_loop_y_idx_last_o <= w_win_last;
          r_state <= ISSUE;
        end
        ISSUE: r_state <= WAIT;
        WAIT: if (inner_loop_finish_i) begin
          if (w_last_chunk && w_row_ge) begin
            out_row_vld_o <= 1'b1;
            out_row_idx_o <= w_row32 - 32'(FIL_SIZE_Y - 1);
            r_state <= DRAIN;
          end else begin
            r_state <= ADV;
          end
        end
        DRAIN: if (out_row_rdy_i) begin
          out_row_vld_o <= 1'b0;
          r_state <= ADV;
        end
        ADV: if (r_row < RW'(IFM_SIZE_Y - 1)) begin
          r_row <= r_row + RW'(1);
          inner_loop_start_o <= 1'b1;
          ifm_loop_y_idx_o <= w_issue_row;
          fil_loop_y_idx_start_o <= w_win_start;
          fil_loop_y_idx_last_o <= w_win_last;
          r_state <= ISSUE;
        end else begin
          r_row <= '0;
          if (!w_last_chunk) begin
            r_chunk <= r_chunk + CW'(1);
            chunk_load_req_o <= 1'b1;
            r_state <= LOAD;
          end else begin
            layer_done_o <= 1'b1;
            busy_o <= 1'b0;
            r_state <= DONE;
          end
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
`ifdef STACKING_OUTER_PERF_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_stall_cyc_o <= '0;
      perf_inner_cyc_o <= '0;
    end else if (r_state == IDLE && layer_start_i) begin
      perf_stall_cyc_o <= '0;
      perf_inner_cyc_o <= '0;
    end else begin
      if (((r_state == LOAD && !chunk_load_ack_i) || (r_state == DRAIN && !out_row_rdy_i)) && ~&perf_stall_cyc_o)
        perf_stall_cyc_o <= perf_stall_cyc_o + 32'd1;
      if (r_state == WAIT && ~&perf_inner_cyc_o)
        perf_inner_cyc_o <= perf_inner_cyc_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_stacking_outer_loop_ctrl.sv
// tb_stacking_outer_loop_ctrl: randomized self-checking bench against an event-list model of a layer
module tb_stacking_outer_loop_ctrl;
  localparam int IFM = 7;
  localparam int FIL = 3;
  localparam int FX = 3;
  localparam int CH = 4;
  localparam int OUT = IFM - FIL + 1;
  logic clk;
  logic rst_ni;
  logic layer_start_i;
  logic [31:0] sub_channel_size_i;
  logic chunk_load_req_o;
  logic chunk_load_ack_i;
  logic inner_loop_start_o;
  logic inner_loop_finish_i;
  logic [31:0] ifm_loop_y_idx_o;
  logic [31:0] fil_loop_y_idx_start_o;
  logic [31:0] fil_loop_y_idx_last_o;
  logic [31:0] fil_loop_y_step_o;
  logic [31:0] sub_channel_size_o;
  logic out_row_vld_o;
  logic [31:0] out_row_idx_o;
  logic out_row_rdy_i;
  logic busy_o;
  logic layer_done_o;
`ifdef STACKING_OUTER_PERF_EN
  logic [31:0] perf_stall_cyc_o;
  logic [31:0] perf_inner_cyc_o;
`endif
  typedef struct {
    logic [31:0] kind;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
  } ev_t;
  ev_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  stacking_outer_loop_ctrl dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .layer_start_i(layer_start_i),
    .sub_channel_size_i(sub_channel_size_i),
    .chunk_load_req_o(chunk_load_req_o),
    .chunk_load_ack_i(chunk_load_ack_i),
    .inner_loop_start_o(inner_loop_start_o),
    .inner_loop_finish_i(inner_loop_finish_i),
    .ifm_loop_y_idx_o(ifm_loop_y_idx_o),
    .fil_loop_y_idx_start_o(fil_loop_y_idx_start_o),
    .fil_loop_y_idx_last_o(fil_loop_y_idx_last_o),
    .fil_loop_y_step_o(fil_loop_y_step_o),
    .sub_channel_size_o(sub_channel_size_o),
    .out_row_vld_o(out_row_vld_o),
    .out_row_idx_o(out_row_idx_o),
    .out_row_rdy_i(out_row_rdy_i),
    .busy_o(busy_o),
    .layer_done_o(layer_done_o)
`ifdef STACKING_OUTER_PERF_EN
    ,
    .perf_stall_cyc_o(perf_stall_cyc_o),
    .perf_inner_cyc_o(perf_inner_cyc_o)
`endif
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0b exp=%0b", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic chk_reset_vals(input string tag);
    chk1({tag, "_req"}, chunk_load_req_o, 1'b0);
    chk1({tag, "_start"}, inner_loop_start_o, 1'b0);
    chk32({tag, "_ifm"}, ifm_loop_y_idx_o, 32'd0);
    chk32({tag, "_fs"}, fil_loop_y_idx_start_o, 32'd0);
    chk32({tag, "_fl"}, fil_loop_y_idx_last_o, 32'd0);
    chk32({tag, "_step"}, fil_loop_y_step_o, 32'(FX));
    chk32({tag, "_sub"}, sub_channel_size_o, 32'd0);
    chk1({tag, "_vld"}, out_row_vld_o, 1'b0);
    chk32({tag, "_oidx"}, out_row_idx_o, 32'd0);
    chk1({tag, "_busy"}, busy_o, 1'b0);
    chk1({tag, "_done"}, layer_done_o, 1'b0);
  endtask
  // Expected event order for one layer: every (chunk,row) issues a start with its window;
  // in the last chunk each row that completes an output row is followed by its drain.
  task automatic build_model();
    ev_t e;
    exp_q.delete();
    for (int c = 0; c < CH; c++)
      for (int r = 0; r < IFM; r++) begin
        e.kind = 0;
        e.a = 32'(r);
        e.b = 32'(r - (OUT - 1) < 0 ? 0 : r - (OUT - 1));
        e.c = 32'(r < FIL - 1 ? r : FIL - 1);
        exp_q.push_back(e);
        if (c == CH - 1 && r >= FIL - 1) begin
          e.kind = 1;
          e.a = 32'(r - (FIL - 1));
          exp_q.push_back(e);
        end
      end
  endtask
  task automatic run_layer(input int ack_d, input int fmax, input bit hold_in, input bit rdy_rand,
                           input int rst_at, input logic [31:0] sub);
    int starts = 0;
    int loads = 0;
    int drains = 0;
    int dones = 0;
    int ack_cnt = 0;
    int fin_left = -1;
    int hold_left = -1;
    int rel_cyc = -1;
    int budget = 0;
    bit hold_en = hold_in;
    bit prev_ack = 0;
    bit prev_vld = 0;
    bit prev_rdy = 1;
    bit rst_pending = 0;
    logic [31:0] prev_idx = '0;
    ev_t e;
    build_model();
    inner_loop_finish_i = 1'b1;
    tick();
    tick();
    inner_loop_finish_i = 1'b0;
    chk1("idle_finish_no_start", inner_loop_start_o, 1'b0);
    chk1("idle_finish_no_req", chunk_load_req_o, 1'b0);
    layer_start_i = 1'b1;
    sub_channel_size_i = sub;
    tick();
    layer_start_i = 1'b0;
    sub_channel_size_i = $urandom;
    chk1("start_to_req", chunk_load_req_o, 1'b1);
    chk1("busy_set", busy_o, 1'b1);
    while (dones == 0 && budget < 4000) begin
      budget++;
      if (rst_pending) begin
        #2;
        rst_ni = 1'b0;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        chunk_load_ack_i = 1'b0;
        inner_loop_finish_i = 1'b0;
        out_row_rdy_i = 1'b0;
        layer_start_i = 1'b0;
        tick();
        chk1("post_rst_idle", busy_o, 1'b0);
        return;
      end
      if (prev_ack) chk1("ack_to_start", inner_loop_start_o, 1'b1);
      if (prev_vld && !prev_rdy) begin
        chk1("vld_held", out_row_vld_o, 1'b1);
        chk32("idx_held", out_row_idx_o, prev_idx);
      end
      if (inner_loop_start_o) begin
        if (rel_cyc >= 0) begin
          chk32("resume_lat", 32'(cyc - rel_cyc), 32'd2);
          rel_cyc = -1;
        end
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else e = '{32'hFFFF_FFFF, 0, 0, 0};
        chk32("ev_kind_start", 32'd0, e.kind);
        chk32("ifm_row", ifm_loop_y_idx_o, e.a);
        chk32("fil_start", fil_loop_y_idx_start_o, e.b);
        chk32("fil_last", fil_loop_y_idx_last_o, e.c);
        starts++;
        if (starts == rst_at + 1) rst_pending = 1;
        fin_left = int'($urandom_range(0, fmax));
        inner_loop_finish_i = 1'($urandom);
      end else if (fin_left >= 0) begin
        inner_loop_finish_i = fin_left == 0;
        fin_left--;
      end else begin
        inner_loop_finish_i = 1'b0;
      end
      if (chunk_load_req_o) begin
        chunk_load_ack_i = ack_cnt >= ack_d;
        ack_cnt++;
      end else begin
        chunk_load_ack_i = 1'b0;
        ack_cnt = 0;
      end
      prev_ack = chunk_load_req_o && chunk_load_ack_i;
      if (prev_ack) loads++;
      if (out_row_vld_o) begin
        chk1("no_start_in_drain", inner_loop_start_o, 1'b0);
        if (hold_en && !prev_vld) begin
          hold_left = 10;
          hold_en = 0;
        end
        if (hold_left > 0) begin
          out_row_rdy_i = 1'b0;
          hold_left--;
        end else if (hold_left == 0) begin
          out_row_rdy_i = 1'b1;
          rel_cyc = cyc;
          hold_left = -1;
        end else begin
          out_row_rdy_i = rdy_rand ? 1'($urandom) : 1'b1;
        end
        if (out_row_rdy_i) begin
          if (exp_q.size() != 0) e = exp_q.pop_front();
          else e = '{32'hFFFF_FFFF, 0, 0, 0};
          chk32("ev_kind_drain", 32'd1, e.kind);
          chk32("out_row_idx", out_row_idx_o, e.a);
          drains++;
        end
      end else begin
        out_row_rdy_i = rdy_rand ? 1'($urandom) : 1'b1;
      end
      prev_vld = out_row_vld_o;
      prev_rdy = out_row_rdy_i;
      prev_idx = out_row_idx_o;
      if (layer_done_o) dones++;
      layer_start_i = !layer_done_o && ($urandom_range(0, 19) == 0);
      tick();
    end
    layer_start_i = 1'b0;
    chk1("layer_finished_in_budget", 1'(dones == 1), 1'b1);
    chk32("start_count", 32'(starts), 32'(CH * IFM));
    chk32("load_count", 32'(loads), 32'(CH));
    chk32("drain_count", 32'(drains), 32'(OUT));
    chk32("model_left", 32'(exp_q.size()), 32'd0);
    chk32("sub_latched", sub_channel_size_o, sub);
    chk32("step", fil_loop_y_step_o, 32'(FX));
    chk1("busy_clear", busy_o, 1'b0);
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      if (layer_done_o) dones++;
      tick();
    end
    chk32("done_once", 32'(dones), 32'd0);
  endtask
  initial begin
    rst_ni = 1'b0;
    layer_start_i = 1'b0;
    sub_channel_size_i = '0;
    chunk_load_ack_i = 1'b0;
    inner_loop_finish_i = 1'b0;
    out_row_rdy_i = 1'b0;
    tick();
    tick();
    chk_reset_vals("reset");
    @(negedge clk);
    rst_ni = 1'b1;
    tick();
    run_layer(0, 0, 0, 0, -1, 32'd16);
    run_layer(int'($urandom_range(0, 3)), 3, 1, 1, -1, 32'h0000_00A5);
    run_layer(int'($urandom_range(0, 2)), 2, 0, 1, 2 * IFM + 3, 32'd7);
    run_layer(1, 3, 0, 1, -1, 32'd99);
`ifdef STACKING_OUTER_PERF_EN
    run_layer(5, 0, 0, 0, -1, 32'd16);
    chk32("perf_stall", perf_stall_cyc_o, 32'd20);
    chk32("perf_inner", perf_inner_cyc_o, 32'(CH * IFM));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/stacking_outer_loop_ctrl.md
Name: stacking_outer_loop_ctrl

Overview:
- Synthesizable sequencer above the stacking inner loop.
- Walks channel chunks and IFM rows, and computes the filter-row window each IFM row contributes to.
- Issues one inner-loop start per row and waits for the inner loop's finish pulse.
- After the last chunk, hands completed output rows to the output drain via valid/ready, and signals layer done.

Parameters:
- IFM_SIZE_Y, 7, IFM rows per layer
- FIL_SIZE_Y, 3, filter rows (stride 1, no padding)
- FIL_SIZE_X, 3, filter columns; driven on fil_loop_y_step_o
- CHUNK_NUM, 4, channel chunks per layer
- OUT_SIZE_Y, IFM_SIZE_Y-FIL_SIZE_Y+1, output rows (derived)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- layer_start_i  in  1  one-cycle start of a layer
- sub_channel_size_i  in  32  sub-channel size, sampled at layer start
- chunk_load_req_o  out  1  request that the next channel chunk be loaded into the buffers
- chunk_load_ack_i  in  1  chunk load complete
- inner_loop_start_o  out  1  one-cycle start pulse to the inner loop
- inner_loop_finish_i  in  1  inner loop finished
- ifm_loop_y_idx_o  out  32  current IFM row
- fil_loop_y_idx_start_o  out  32  first contributing filter row
- fil_loop_y_idx_last_o  out  32  last contributing filter row
- fil_loop_y_step_o  out  32  constant FIL_SIZE_X
- sub_channel_size_o  out  32  latched sub-channel size
- out_row_vld_o  out  1  output row complete
- out_row_idx_o  out  32  index of the completed output row
- out_row_rdy_i  in  1  drain accepts the row
- busy_o  out  1  layer in progress
- layer_done_o  out  1  one-cycle pulse at layer end

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_ni is asynchronous, active-low.
- Reset values: all outputs 0 except fil_loop_y_step_o = FIL_SIZE_X. Counters chunk_idx and row_idx = 0. State IDLE.
- IDLE:
  - On layer_start_i, latch sub_channel_size_i, clear the counters, set busy_o, go to LOAD.
  - layer_start_i is ignored in every other state.
- LOAD:
  - Hold chunk_load_req_o = 1 until chunk_load_ack_i is sampled high, then go to ISSUE.
  - Request deasserts in the cycle after the ack.
- ISSUE:
  - Registered outputs: ifm_loop_y_idx_o = row_idx; start = max(0, row_idx - (OUT_SIZE_Y-1)); last = min(FIL_SIZE_Y-1, row_idx).
  - Pulse inner_loop_start_o for exactly one cycle with these values already stable on the same edge. Go to WAIT.
  - Indices stay stable until the next ISSUE.
- WAIT:
  - On inner_loop_finish_i:
    - if chunk_idx == CHUNK_NUM-1 and row_idx >= FIL_SIZE_Y-1, go to DRAIN;
    - otherwise go to ADV.
  - inner_loop_finish_i is ignored outside WAIT, including in the ISSUE cycle.
- DRAIN:
  - out_row_vld_o = 1 with out_row_idx_o = row_idx-(FIL_SIZE_Y-1).
  - Valid and index are held until out_row_rdy_i is high on a clock edge, then go to ADV.
  - If rdy is already high on the first DRAIN cycle, the handshake completes in that one cycle.
- ADV:
  - row_idx < IFM_SIZE_Y-1: row_idx++, go to ISSUE.
  - Otherwise row_idx = 0, then:
    - chunk_idx < CHUNK_NUM-1: chunk_idx++, go to LOAD;
    - else go to DONE.
- DONE: pulse layer_done_o for one cycle, clear busy_o, go to IDLE.
- Arithmetic:
  - Window computations use 32-bit signed compares, so no underflow occurs.
  - The row counter needs clog2(IFM_SIZE_Y) bits, zero-extended onto the 32-bit outputs.
- Latency:
  - layer_start to the first chunk_load_req_o: 1 cycle.
  - ack to inner_loop_start_o: 1 cycle.
  - finish to the next start: 2 cycles (WAIT→ADV→ISSUE) when there is no drain.
- Reset mid-operation: immediate return to IDLE with reset values; any pending handshake is abandoned.

Optional Feature:
- Macro: STACKING_OUTER_PERF_EN.
- Defined:
  - Adds output perf_stall_cyc_o [31:0], counting cycles spent in LOAD or DRAIN with the handshake incomplete.
  - Adds output perf_inner_cyc_o [31:0], counting cycles spent in WAIT.
  - Both clear at layer_start_i and saturate at all-ones.
- Undefined: these ports and the counters do not exist. All other behaviour is identical.

Decomposition:
- Package stacking_pkg:
  - state enum (IDLE, LOAD, ISSUE, WAIT, DRAIN, ADV, DONE);
  - a function computing the filter window (row → start/last);
  - a loop_idx_t typedef.
- Sub-module stacking_row_window: combinational/registered computation of the start/last window, reused by the inner-loop RTL.

Test Plan:
- Defaults (7,3,3,4), sub_channel_size_i = 16, immediate ack/finish/rdy:
  - 28 inner_loop_start_o pulses and 4 chunk loads;
  - row windows 0:0..0, 1:0..1, 2..4:0..2, 5:1..2, 6:2..2;
  - sub_channel_size_o = 16; layer_done_o once.
- Last chunk: exactly 5 out_row_vld_o handshakes with idx 0..4, after rows 2..6; none in earlier chunks.
- out_row_rdy_i low for 10 cycles: valid and index held stable, no new inner_loop_start_o, resumes 2 cycles after rdy.
- inner_loop_finish_i asserted in the ISSUE cycle and in IDLE: ignored; the sequence count is unchanged.
- rst_ni dropped in WAIT of chunk 2, row 3: all outputs reset asynchronously; a new layer_start_i runs a full 28-start layer.
- With STACKING_OUTER_PERF_EN, ack delayed 5 cycles per chunk and rdy always high: perf_stall_cyc_o = 20.
